// File: rtl/pipelined_io_computer.sv
// Five-stage MIPS-subset lab computer: internal ROM program, data RAM, memory-mapped I/O and 7-segment readout.
// Build option PIPELINE_FORWARDING_EN enables EX/MEM and MEM/WB bypassing; without it RAW hazards stall in ID.
module pipelined_io_computer #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  input  logic        in_port_sub,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        LEDR4
);
  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  function automatic logic [31:0] rom_word(input logic [IA_W-1:0] a);
    case (int'(a))
      0:       rom_word = 32'h8C010080; // lw  r1,0x80(r0)
      1:       rom_word = 32'h8C020084; // lw  r2,0x84(r0)
      2:       rom_word = 32'h8C030088; // lw  r3,0x88(r0)
      3:       rom_word = 32'hAC010080; // sw  r1,0x80(r0)
      4:       rom_word = 32'hAC020084; // sw  r2,0x84(r0)
      5:       rom_word = 32'h10600002; // beq r3,r0,ADD
      6:       rom_word = 32'h00222022; // sub r4,r1,r2
      7:       rom_word = 32'h08000009; // j   ST
      8:       rom_word = 32'h00222020; // ADD: add r4,r1,r2
      9:       rom_word = 32'hAC040088; // ST: sw r4,0x88(r0)
      10:      rom_word = 32'h08000000; // j   0
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  assign inst = rom_word(pc[IA_W+1:2]);

  // Pipeline registers
  logic [31:0] ifid_inst, ifid_pc4;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_imm;
  alu_op_t     idex_alu_op;
  logic [4:0]  idex_rs, idex_rt, idex_wreg;
  logic [31:0] idex_a, idex_b, idex_imm;
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]  exmem_wreg;
  logic [31:0] exmem_alu, exmem_sd;
  logic        memwb_reg_write;
  logic [4:0]  memwb_wreg;
  logic [31:0] memwb_wdata;
  logic [31:0] rf [32];
  logic [31:0] dmem [DMEM_WORDS];

  // ID decode
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm;
  logic        d_reg_write, d_mem_read, d_mem_write, d_alu_imm;
  logic        d_uses_rs, d_uses_rt, d_beq, d_bne, d_jump;
  alu_op_t     d_alu_op;
  logic [4:0]  d_wreg;

  assign id_op    = ifid_inst[31:26];
  assign id_rs    = ifid_inst[25:21];
  assign id_rt    = ifid_inst[20:16];
  assign id_rd    = ifid_inst[15:11];
  assign id_funct = ifid_inst[5:0];
  assign id_imm   = {{16{ifid_inst[15]}}, ifid_inst[15:0]};

  always_comb begin
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_alu_imm   = 1'b0;
    d_uses_rs   = 1'b0;
    d_uses_rt   = 1'b0;
    d_beq       = 1'b0;
    d_bne       = 1'b0;
    d_jump      = 1'b0;
    d_alu_op    = ALU_ADD;
    d_wreg      = 5'd0;
    case (id_op)
      OP_RTYPE: begin
        d_reg_write = 1'b1;
        d_uses_rs   = 1'b1;
        d_uses_rt   = 1'b1;
        d_wreg      = id_rd;
        case (id_funct)
          6'h20:   d_alu_op = ALU_ADD;
          6'h22:   d_alu_op = ALU_SUB;
          6'h24:   d_alu_op = ALU_AND;
          6'h25:   d_alu_op = ALU_OR;
          6'h2A:   d_alu_op = ALU_SLT;
          default: begin
            d_reg_write = 1'b0;
            d_uses_rs   = 1'b0;
            d_uses_rt   = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        d_reg_write = 1'b1; d_uses_rs = 1'b1; d_alu_imm = 1'b1; d_wreg = id_rt;
      end
      OP_LW: begin
        d_reg_write = 1'b1; d_mem_read = 1'b1; d_uses_rs = 1'b1; d_alu_imm = 1'b1; d_wreg = id_rt;
      end
      OP_SW: begin
        d_mem_write = 1'b1; d_uses_rs = 1'b1; d_uses_rt = 1'b1; d_alu_imm = 1'b1;
      end
      OP_BEQ:  begin d_beq = 1'b1; d_uses_rs = 1'b1; d_uses_rt = 1'b1; end
      OP_BNE:  begin d_bne = 1'b1; d_uses_rs = 1'b1; d_uses_rt = 1'b1; end
      OP_J:    d_jump = 1'b1;
      default: ;
    endcase
  end

  // Register reads see the WB-stage write in the same cycle (write-before-read)
  logic [31:0] id_a, id_b;
  always_comb begin
    id_a = rf[id_rs];
    id_b = rf[id_rt];
    if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == id_rs) id_a = memwb_wdata;
    if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == id_rt) id_b = memwb_wdata;
`ifdef PIPELINE_FORWARDING_EN
    if (exmem_reg_write && !exmem_mem_read && exmem_wreg != 5'd0 && exmem_wreg == id_rs) id_a = exmem_alu;
    if (exmem_reg_write && !exmem_mem_read && exmem_wreg != 5'd0 && exmem_wreg == id_rt) id_b = exmem_alu;
`endif
  end

  logic ex_hit, mem_hit, stall, take;
  logic [31:0] target;
  assign ex_hit  = idex_reg_write && idex_wreg != 5'd0 &&
                   ((d_uses_rs && idex_wreg == id_rs) || (d_uses_rt && idex_wreg == id_rt));
  assign mem_hit = exmem_reg_write && exmem_wreg != 5'd0 &&
                   ((d_uses_rs && exmem_wreg == id_rs) || (d_uses_rt && exmem_wreg == id_rt));
`ifdef PIPELINE_FORWARDING_EN
  assign stall = (ex_hit && (idex_mem_read || d_beq || d_bne)) ||
                 (mem_hit && exmem_mem_read && (d_beq || d_bne));
`else
  assign stall = ex_hit || mem_hit;
`endif
  assign take   = !stall && (d_jump || (d_beq && id_a == id_b) || (d_bne && id_a != id_b));
  assign target = d_jump ? {ifid_pc4[31:28], ifid_inst[25:0], 2'b00}
                         : ifid_pc4 + {id_imm[29:0], 2'b00};

  // EX stage
  logic [31:0] ex_a, ex_b, alu_b, alu_y;
  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
`ifdef PIPELINE_FORWARDING_EN
    if (exmem_reg_write && exmem_wreg != 5'd0 && exmem_wreg == idex_rs) ex_a = exmem_alu;
    else if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == idex_rs) ex_a = memwb_wdata;
    if (exmem_reg_write && exmem_wreg != 5'd0 && exmem_wreg == idex_rt) ex_b = exmem_alu;
    else if (memwb_reg_write && memwb_wreg != 5'd0 && memwb_wreg == idex_rt) ex_b = memwb_wdata;
`endif
    alu_b = idex_alu_imm ? idex_imm : ex_b;
    case (idex_alu_op)
      ALU_SUB: alu_y = ex_a - alu_b;
      ALU_AND: alu_y = ex_a & alu_b;
      ALU_OR:  alu_y = ex_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(ex_a) < $signed(alu_b)};
      default: alu_y = ex_a + alu_b;
    endcase
  end

  // MEM stage: addr[7] selects I/O space
  logic            mem_io;
  logic [DA_W-1:0] mem_idx;
  logic [31:0]     mem_rdata;
  assign mem_io  = exmem_alu[7];
  assign mem_idx = exmem_alu[DA_W+1:2];
  always_comb begin
    mem_rdata = 32'd0;
    if (mem_io) begin
      case (exmem_alu[7:0])
        8'h80:   mem_rdata = {28'd0, in_port0};
        8'h84:   mem_rdata = {28'd0, in_port1};
        8'h88:   mem_rdata = {31'd0, in_port_sub};
        default: mem_rdata = 32'd0;
      endcase
    end else begin
      mem_rdata = dmem[mem_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (exmem_mem_write && !mem_io) dmem[mem_idx] <= exmem_sd;
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      pc              <= 32'd0;
      ifid_inst       <= 32'd0;
      ifid_pc4        <= 32'd0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_alu_imm    <= 1'b0;
      idex_alu_op     <= ALU_ADD;
      idex_rs         <= 5'd0;
      idex_rt         <= 5'd0;
      idex_wreg       <= 5'd0;
      idex_a          <= 32'd0;
      idex_b          <= 32'd0;
      idex_imm        <= 32'd0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_wreg      <= 5'd0;
      exmem_alu       <= 32'd0;
      exmem_sd        <= 32'd0;
      memwb_reg_write <= 1'b0;
      memwb_wreg      <= 5'd0;
      memwb_wdata     <= 32'd0;
      out_port0       <= 32'd0;
      out_port1       <= 32'd0;
      out_port2       <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (!stall) begin
        pc        <= take ? target : pc + 32'd4;
        ifid_inst <= take ? 32'd0 : inst;
        ifid_pc4  <= take ? 32'd0 : pc + 32'd4;
      end
      // A stall keeps IF/ID and sends a bubble into EX
      idex_reg_write  <= stall ? 1'b0 : d_reg_write;
      idex_mem_read   <= stall ? 1'b0 : d_mem_read;
      idex_mem_write  <= stall ? 1'b0 : d_mem_write;
      idex_alu_imm    <= d_alu_imm;
      idex_alu_op     <= d_alu_op;
      idex_rs         <= id_rs;
      idex_rt         <= id_rt;
      idex_wreg       <= stall ? 5'd0 : d_wreg;
      idex_a          <= id_a;
      idex_b          <= id_b;
      idex_imm        <= id_imm;
      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;
      exmem_wreg      <= idex_wreg;
      exmem_alu       <= alu_y;
      exmem_sd        <= ex_b;
      memwb_reg_write <= exmem_reg_write;
      memwb_wreg      <= exmem_wreg;
      memwb_wdata     <= exmem_mem_read ? mem_rdata : exmem_alu;
      if (exmem_mem_write && mem_io) begin
        case (exmem_alu[7:0])
          8'h80:   out_port0 <= exmem_sd;
          8'h84:   out_port1 <= exmem_sd;
          8'h88:   out_port2 <= exmem_sd;
          default: ;
        endcase
      end
      if (memwb_reg_write && memwb_wreg != 5'd0) rf[memwb_wreg] <= memwb_wdata;
    end
  end

  // Displays
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] dec2(input logic [7:0] v);
    dec2 = {seg7(4'((v / 8'd10) % 8'd10)), seg7(4'(v % 8'd10))};
  endfunction

  logic [31:0] mag2;
  assign mag2 = out_port2[31] ? (32'd0 - out_port2) : out_port2;
  assign {HEX1, HEX0} = dec2({4'd0, out_port0[3:0]});
  assign {HEX3, HEX2} = dec2({4'd0, out_port1[3:0]});
  assign {HEX5, HEX4} = dec2(mag2[7:0]);
  assign LEDR4 = out_port2[31];

  logic unused_bits;
  assign unused_bits = ^{ifid_inst[10:6], mag2[31:8]};
endmodule

// File: tb/tb_pipelined_io_computer.sv
// Self-checking bench for pipelined_io_computer: reset state, vector table, loop period, mid-run reset, stepped operands.
module tb_pipelined_io_computer;
  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] pc, inst, out_port0, out_port1, out_port2;
  logic [3:0]  in_port0 = 4'd0, in_port1 = 4'd0;
  logic        in_port_sub = 1'b0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        LEDR4;

  int n_checks = 0;
  int n_errors = 0;
  logic [95:0] exp_q[$];

  pipelined_io_computer dut (
    .clock(clock), .resetn(resetn), .pc(pc), .inst(inst),
    .in_port0(in_port0), .in_port1(in_port1), .in_port_sub(in_port_sub),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR4(LEDR4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        s;
    logic [31:0] p2;
    logic [6:0]  h5;
    logic [6:0]  h4;
    logic [6:0]  h1;
    logic [6:0]  h0;
    logic        led;
  } vec_t;
  vec_t vec [6];

`ifdef PIPELINE_FORWARDING_EN
  localparam int EXP_PERIOD_ADD = 11;
`else
  localparam int EXP_PERIOD_ADD = 13;
`endif
  localparam int EXP_PERIOD_SUB = 12;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    return s ? ({28'd0, a} - {28'd0, b}) : ({28'd0, a} + {28'd0, b});
  endfunction

  function automatic int mag_of(input logic [31:0] v);
    int sv;
    sv = $signed(v);
    return (sv < 0) ? -sv : sv;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s);
    in_port0 = a;
    in_port1 = b;
    in_port_sub = s;
    exp_q.push_back({28'd0, a, 28'd0, b, model(a, b, s)});
  endtask

  task automatic sb_check(input string tag);
    logic [95:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_queue: got empty want entry", tag);
      return;
    end
    n_checks--;
    e = exp_q.pop_front();
    check({tag, "_p0"}, out_port0, e[95:64]);
    check({tag, "_p1"}, out_port1, e[63:32]);
    check({tag, "_p2"}, out_port2, e[31:0]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_p0"}, out_port0, 32'd0);
    check({tag, "_p1"}, out_port1, 32'd0);
    check({tag, "_p2"}, out_port2, 32'd0);
    check({tag, "_hex"}, {4'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {4'd0, {6{7'h40}}});
    check({tag, "_led"}, 32'(LEDR4), 32'd0);
  endtask

  task automatic measure_period(output int period);
    int t;
    period = -1;
    t = 0;
    while (pc != 32'd0 && t < 100) begin @(negedge clock); t++; end
    if (pc != 32'd0) return;
    @(negedge clock);
    t = 1;
    while (pc != 32'd0 && t < 100) begin @(negedge clock); t++; end
    if (pc == 32'd0) period = t;
  endtask

  initial begin
    int period;
    logic [3:0] a, b;
    logic s;
    int m;

    vec[0] = '{4'd3,  4'd5,  1'b0, 32'h00000008, 7'h40, 7'h00, 7'h40, 7'h30, 1'b0};
    vec[1] = '{4'd3,  4'd5,  1'b1, 32'hFFFFFFFE, 7'h40, 7'h24, 7'h40, 7'h30, 1'b1};
    vec[2] = '{4'd15, 4'd15, 1'b0, 32'h0000001E, 7'h30, 7'h40, 7'h79, 7'h12, 1'b0};
    vec[3] = '{4'd0,  4'd15, 1'b1, 32'hFFFFFFF1, 7'h79, 7'h12, 7'h40, 7'h40, 1'b1};
    vec[4] = '{4'd9,  4'd0,  1'b1, 32'h00000009, 7'h40, 7'h10, 7'h40, 7'h10, 1'b0};
    vec[5] = '{4'd0,  4'd0,  1'b0, 32'h00000000, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0};

    // Reset for 3 cycles, then sequential fetch up to the taken beq
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    check_reset_state("reset");
    check("reset_inst", inst, 32'h8C010080);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      check($sformatf("pc_step%0d", i), pc, 32'(4 * i));
    end
    @(negedge clock);
    check("pc_after_beq_taken", pc, 32'h20);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      drive(vec[i].a, vec[i].b, vec[i].s);
      repeat (40) @(negedge clock);
      sb_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d_hex5", i), 32'(HEX5), 32'(vec[i].h5));
      check($sformatf("vec%0d_hex4", i), 32'(HEX4), 32'(vec[i].h4));
      check($sformatf("vec%0d_hex1", i), 32'(HEX1), 32'(vec[i].h1));
      check($sformatf("vec%0d_hex0", i), 32'(HEX0), 32'(vec[i].h0));
      check($sformatf("vec%0d_led", i), 32'(LEDR4), 32'(vec[i].led));
    end

    // Loop period on each branch path
    drive(4'd3, 4'd5, 1'b0);
    repeat (40) @(negedge clock);
    sb_check("period_add_pre");
    measure_period(period);
    check("period_add", 32'(period), 32'(EXP_PERIOD_ADD));
    drive(4'd3, 4'd5, 1'b1);
    repeat (40) @(negedge clock);
    sb_check("period_sub_pre");
    measure_period(period);
    check("period_sub", 32'(period), 32'(EXP_PERIOD_SUB));

    // Mid-run reset
    repeat (5) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_reset_state("midreset");
    resetn = 1'b0;
    drive(4'd7, 4'd2, 1'b1);
    @(negedge clock);
    check("midreset_pc4", pc, 32'd4);
    repeat (40) @(negedge clock);
    sb_check("midreset_run");

    // Stepped operands, mode toggled every 1000 cycles
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    s = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) s = ~s;
      drive(a, b, s);
      repeat (32) @(negedge clock);
      sb_check($sformatf("step%0d", k));
      m = mag_of(model(a, b, s));
      check($sformatf("step%0d_hex3", k), 32'(HEX3), 32'(seg_ref(int'(b) / 10)));
      check($sformatf("step%0d_hex2", k), 32'(HEX2), 32'(seg_ref(int'(b) % 10)));
      check($sformatf("step%0d_hex54", k), 32'({HEX5, HEX4}), 32'({seg_ref((m / 10) % 10), seg_ref(m % 10)}));
      check($sformatf("step%0d_led", k), 32'(LEDR4), 32'(model(a, b, s) >> 31));
      repeat (18) @(negedge clock);
      a = a + 4'd1;
      b = b + 4'd1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipelined_io_computer.md
Name: pipelined_io_computer

Overview:
- Small 5-stage (IF/ID/EX/MEM/WB) MIPS-subset processor with internal instruction ROM, internal data RAM and memory-mapped I/O.
- Top-level lab block. Runs a fixed program that reads two 4-bit operands and a mode switch, then computes a sum or difference.
- Drives three 32-bit output ports, six 7-segment displays and a sign LED.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words (word-addressed by pc[7:2]).
- DMEM_WORDS, 32, data RAM depth in 32-bit words (word-addressed by addr[6:2]).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-high reset; the port name is kept for codebase compatibility.
- pc  out  32  current IF-stage program counter.
- inst  out  32  instruction fetched at pc.
- in_port0  in  4  operand A, zero-extended on read.
- in_port1  in  4  operand B, zero-extended on read.
- in_port_sub  in  1  mode select: 0 = add, 1 = subtract.
- out_port0  out  32  last value stored to I/O address 0x80.
- out_port1  out  32  last value stored to I/O address 0x84.
- out_port2  out  32  last value stored to I/O address 0x88.
- HEX0..HEX5  out  7 each  active-low segments; bit0 = a … bit6 = g.
- LEDR4  out  1  high when out_port2 is negative (bit 31 set).

Behaviour:
- Reset, held while resetn=1 at a clock edge:
  - pc=0; all pipeline registers cleared to NOP (0x00000000).
  - Register file r0..r31 = 0; out_port0/1/2 = 0; LEDR4 = 0.
  - Every HEX shows the digit "0" (7'b1000000).
  - Data RAM contents are not reset.
- ISA: add, sub, and, or, slt (R-type); addi, lw, sw, beq, bne (I-type); j.
  - r0 is hardwired to 0.
  - Any other opcode executes as a NOP.
- Branches and jumps:
  - beq/bne compare and j target computation are done in ID.
  - When taken, the IF instruction is flushed to NOP (one-cycle penalty, no delay slot).
  - Branch target = pc+4 + (sext(imm)<<2).
- Hazards:
  - Full EX/MEM→EX and MEM/WB→EX forwarding.
  - Register file writes in the first half of the cycle (write-before-read).
  - Load-use hazard: stall pc and IF/ID for 1 cycle and insert a bubble in EX.
  - A branch depending on an ALU result in EX, or on a load in EX/MEM, stalls until the operand can be forwarded to ID.
- Memory map:
  - addr[7]=0: data RAM.
  - addr[7]=1: I/O.
  - Loads: 0x80 = {28'b0,in_port0}, 0x84 = {28'b0,in_port1}, 0x88 = {31'b0,in_port_sub}.
  - Stores to 0x80/0x84/0x88 update out_port0/1/2 at the end of MEM.
  - Other I/O addresses read as 0; stores to them are ignored.
- ROM program, loops forever:
  - lw r1,0x80(r0); lw r2,0x84(r0); lw r3,0x88(r0)
  - sw r1,0x80(r0); sw r2,0x84(r0)
  - beq r3,r0,ADD
  - sub r4,r1,r2; j ST
  - ADD: add r4,r1,r2
  - ST: sw r4,0x88(r0); j 0
- Latency: outputs reflect new inputs within 32 cycles of any input change.
- Arithmetic: 32-bit two's complement; overflow is ignored.
- Displays, updated combinationally from the out ports:
  - HEX1:HEX0 = decimal tens:units of out_port0[3:0] (0–15).
  - HEX3:HEX2 = decimal tens:units of out_port1[3:0].
  - HEX5:HEX4 = decimal tens:units of |out_port2| (0–30).
  - Tens digit 0 displays "0".
  - LEDR4 = out_port2[31].
- Mid-operation reset: takes effect on the next edge, discards all in-flight instructions and restarts at pc=0.

Optional Feature:
- Macro: PIPELINE_FORWARDING_EN.
- Defined: forwarding paths as in Behaviour; stalls only for load-use and branch-operand cases.
- Undefined: no forwarding paths. Any RAW dependency on an instruction in EX, MEM or WB stalls in ID until the producer has written back.
- Architectural results must be identical in both builds; only cycle counts differ.

Test Plan:
- Reset held 3 cycles, then released -> pc=0, inst=ROM[0], out ports 0, HEX all "0", LEDR4=0; pc advances by 4 each cycle until the first taken branch.
- in_port0=3, in_port1=5, in_port_sub=0, wait 40 cycles -> out_port0=3, out_port1=5, out_port2=8; HEX5:HEX4 = "0","8"; LEDR4=0.
- Same operands, in_port_sub=1, wait 40 cycles -> out_port2=0xFFFFFFFE (-2); LEDR4=1; HEX5:HEX4 = "0","2".
- in_port0=15, in_port1=15, add -> out_port2=30; HEX1:HEX0="1","5"; HEX5:HEX4="3","0".
- Load-use and taken-branch paths -> no instruction executes twice or out of order; out_port1 is written before out_port2 on every loop. Bench checks loop period = program length + stall and flush cycles, with and without PIPELINE_FORWARDING_EN.
- Step both operands +1 every 50 cycles while toggling in_port_sub every 1000 cycles -> every sampled out_port2 equals the add or sub of the current operands within 32 cycles of each change.
